// File: rtl/mult_pkg.sv
// Shared types and constants for the radix-4 sequential multiplier.
// Holds the FSM state enum, digit width and CALC cycle count helper.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int DIGIT_W = 2;

  function automatic int calc_cycles(input int width);
    return width / DIGIT_W;
  endfunction

endpackage

// File: rtl/mult_digit_pp.sv
// Combinational WIDTH x 2-bit partial product: 0, A, 2A or 3A.
// Ports: a (multiplicand), digit (2-bit multiplier digit), pp (WIDTH+2 result).
module mult_digit_pp
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [DIGIT_W-1:0] digit,
  output logic [WIDTH+1:0]   pp
);

  always_comb begin
    pp = '0;
    unique case (digit)
      2'd0: pp = '0;
      2'd1: pp = {2'b00, a};
      2'd2: pp = {1'b0, a, 1'b0};
      default: pp = {2'b00, a} + {1'b0, a, 1'b0};
    endcase
  end

endmodule

// File: rtl/seq_mult_radix4.sv
// Unsigned iterative multiplier, one 2-bit digit per cycle, valid/ready I/O.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/a/b,
// out_valid/out_ready/product. Option: EARLY_TERM_EN ends CALC once
// the remaining multiplier digits are all zero.
module seq_mult_radix4
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int NCYC = calc_cycles(WIDTH);
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  state_t               state;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;

  logic [WIDTH+1:0]     pp;
  logic [2*WIDTH-1:0]   pp_sh;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic                 last;

  mult_digit_pp #(
    .WIDTH (WIDTH)
  ) u_pp (
    .a     (a_r),
    .digit (b_r[DIGIT_W-1:0]),
    .pp    (pp)
  );

  // Digit weight is 4^cnt, i.e. a left shift by 2*cnt.
  assign pp_sh   = {{(WIDTH-2){1'b0}}, pp} << {cnt, 1'b0};
  assign acc_nxt = acc + pp_sh;

`ifdef EARLY_TERM_EN
  // Remaining digits zero: further cycles would only add zero.
  assign last = (cnt == CW'(NCYC-1)) ||
                (b_r[WIDTH-1:DIGIT_W] == '0);
`else
  assign last = (cnt == CW'(NCYC-1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          b_r <= b_r >> DIGIT_W;
          cnt <= cnt + CW'(1);
          if (last) begin
            product   <= acc_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_radix4.sv
// Self-checking bench for seq_mult_radix4 at WIDTH 8, 4 and 16.
// Vector table, directed corner sequences, random sweep vs a*b.
module tb_seq_mult_radix4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  logic        aux_rst;
  logic        w4_in_valid, w4_in_ready, w4_out_valid, w4_out_ready;
  logic [3:0]  w4_a, w4_b;
  logic [7:0]  w4_product;
  logic        w16_in_valid, w16_in_ready, w16_out_valid, w16_out_ready;
  logic [15:0] w16_a, w16_b;
  logic [31:0] w16_product;

  int tests = 0;
  int fails = 0;
  bit aux_done = 1'b0;
  bit w16_stop = 1'b0;
  logic [7:0]  w4_q[$];
  logic [31:0] w16_q[$];

  always #5 clk = ~clk;

  seq_mult_radix4 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product)
  );

  seq_mult_radix4 #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(aux_rst), .in_valid(w4_in_valid),
    .in_ready(w4_in_ready), .a(w4_a), .b(w4_b),
    .out_valid(w4_out_valid), .out_ready(w4_out_ready),
    .product(w4_product)
  );

  seq_mult_radix4 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(aux_rst), .in_valid(w16_in_valid),
    .in_ready(w16_in_ready), .a(w16_a), .b(w16_b),
    .out_valid(w16_out_valid), .out_ready(w16_out_ready),
    .product(w16_product)
  );

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] exp_p;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Number of CALC cycles the multiplier spends on operand b.
  function automatic int exp_lat(input logic [63:0] bv, input int w);
    int n;
    n = w / 2;
`ifdef EARLY_TERM_EN
    n = 1;
    while (n < w / 2 && (bv >> (2 * n)) != 0) n++;
`endif
    return n;
  endfunction

  task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                        input int stall, input int inject,
                        output logic [15:0] p, output int lat,
                        output bit ir_low);
    int k;
    k = 0;
    a = va;
    b = vb;
    in_valid = 1'b1;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) check("accept_timeout", k, 0);
    tick();
    in_valid = 1'b0;
    out_ready = (stall == 0);
    lat = 0;
    ir_low = 1'b1;
    while (!out_valid && lat < 64) begin
      if (in_ready) ir_low = 1'b0;
      if (lat == inject) begin
        in_valid = 1'b1;
        a = 8'd1;
        b = 8'd1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    p = product;
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      tick();
      check("hold_product", product, p);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
  endtask

  always @(negedge clk) begin
    if (!aux_rst && w4_out_valid && w4_out_ready) begin
      if (w4_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL w4_extra: got %0h expected none", w4_product);
      end else begin
        check("w4_product", w4_product, w4_q.pop_front());
      end
    end
    if (!aux_rst && w16_out_valid && w16_out_ready) begin
      if (w16_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL w16_extra: got %0h expected none", w16_product);
      end else begin
        check("w16_product", w16_product, w16_q.pop_front());
      end
    end
  end

  initial begin : aux_proc
    int w4_to;
    int w16_to;
    w4_to = 0;
    w16_to = 0;
    aux_rst = 1'b1;
    w4_in_valid = 1'b0; w4_out_ready = 1'b1; w4_a = '0; w4_b = '0;
    w16_in_valid = 1'b0; w16_out_ready = 1'b0; w16_a = '0; w16_b = '0;
    repeat (3) tick();
    aux_rst = 1'b0;
    fork
      begin
        for (int x = 0; x < 16; x++) begin
          for (int y = 0; y < 16; y++) begin
            int k;
            k = 0;
            w4_a = x[3:0];
            w4_b = y[3:0];
            w4_in_valid = 1'b1;
            while (!w4_in_ready && k < 100) begin
              tick();
              k++;
            end
            if (k >= 100) w4_to++;
            w4_q.push_back(8'(x * y));
            tick();
            w4_in_valid = 1'b0;
          end
        end
      end
      begin
        for (int n = 0; n < 500; n++) begin
          int k;
          k = 0;
          w16_a = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
          w16_b = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
          w16_in_valid = 1'b1;
          while (!w16_in_ready && k < 200) begin
            tick();
            k++;
          end
          if (k >= 200) w16_to++;
          w16_q.push_back({16'h0, w16_a} * {16'h0, w16_b});
          tick();
          w16_in_valid = 1'b0;
        end
      end
      begin
        while (!w16_stop) begin
          tick();
          w16_out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        int k;
        k = 0;
        while (k < 20000 && !(w16_q.size() == 0 && k > 8000)) begin
          tick();
          k++;
        end
        w16_stop = 1'b1;
      end
    join
    begin
      int k;
      k = 0;
      w16_out_ready = 1'b1;
      while ((w4_q.size() != 0 || w16_q.size() != 0) && k < 200) begin
        tick();
        k++;
      end
    end
    check("w4_drain", w4_q.size(), 0);
    check("w16_drain", w16_q.size(), 0);
    check("w4_timeouts", w4_to, 0);
    check("w16_timeouts", w16_to, 0);
    aux_done = 1'b1;
  end

  initial begin : main_proc
    vec_t        vecs[10];
    logic [15:0] p;
    int          lat;
    bit          ir_low;
    int          k;

    vecs[0] = '{8'd13,  8'd11,  16'd143};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd0,   8'd200, 16'd0};
    vecs[3] = '{8'd200, 8'd0,   16'd0};
    vecs[4] = '{8'd7,   8'd3,   16'd21};
    vecs[5] = '{8'd1,   8'd255, 16'd255};
    vecs[6] = '{8'd128, 8'd2,   16'd256};
    vecs[7] = '{8'd255, 8'd1,   16'd255};
    vecs[8] = '{8'd17,  8'd64,  16'd1088};
    vecs[9] = '{8'd200, 8'd150, 16'd30000};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", in_ready, 1);

    foreach (vecs[i]) begin
      run_op(vecs[i].va, vecs[i].vb, 0, -1, p, lat, ir_low);
      check("vec_product", p, vecs[i].exp_p);
      check("vec_latency", lat, exp_lat(vecs[i].vb, 8));
      check("vec_in_ready_low", ir_low, 1);
    end

    run_op(8'd100, 8'd50, 6, -1, p, lat, ir_low);
    check("bp_product", p, 16'd5000);

    run_op(8'd9, 8'd9, 0, 1, p, lat, ir_low);
    check("inject_product", p, 16'd81);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) k++;
    end
    check("inject_no_extra", k, 0);
    check("inject_in_ready", in_ready, 1);

    a = 8'd77;
    b = 8'd33;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_product", product, 0);
    run_op(8'd3, 8'd5, 0, -1, p, lat, ir_low);
    check("midrst_next", p, 16'd15);

    for (int n = 0; n < 2000; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 3))
                                       : 8'($urandom);
      run_op(ra, rb, $urandom_range(0, 3), -1, p, lat, ir_low);
      check("rand_product", p, {8'h0, ra} * {8'h0, rb});
      check("rand_latency", lat, exp_lat(rb, 8));
    end

    k = 0;
    while (!aux_done && k < 50000) begin
      tick();
      k++;
    end
    check("aux_done", aux_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
